unit_realigner: RTL and testbench
=================================

// Module: unit_realigner
// PURPOSE
//  Streaming realigner. Drops the first OFFSET units of each frame and repacks the rest
//  into full output words, so that unit 0 of the first output word is the first kept unit.
//  Sits upstream of header/field extractors that expect word-aligned payload.
//  Uses left rotation by OFFSET plus a one-word residue register. Registered valid/ready output.
// PARAMETERS
//  UNIT_SIZE   8                    bits per unit
//  NUM_UNITS   8                    units per word (power of 2, >=2)
//  DATA_WIDTH  UNIT_SIZE*NUM_UNITS  word width, unit 0 at bit index 0 (MSB side, [0:W-1])
//  OFF_WIDTH   log2(NUM_UNITS)      width of offset
//  CNT_WIDTH   log2(NUM_UNITS)+1    width of a valid-unit count, range 1..NUM_UNITS
// PORTS
//  clk            in   1          single clock
//  reset          in   1          asynchronous, active-high
//  in_data        in   DATA_WIDTH input word [0:DATA_WIDTH-1]
//  in_sof         in   1          first word of frame
//  in_eof         in   1          last word of frame
//  in_eof_units   in   CNT_WIDTH  valid units in eof word (1..NUM_UNITS), ignored otherwise
//  in_offset      in   OFF_WIDTH  units to drop; sampled only on accepted sof word
//  in_vld         in   1          input valid
//  in_rdy         out  1          input ready
//  out_data       out  DATA_WIDTH aligned word
//  out_eof        out  1          last output word of frame
//  out_eof_units  out  CNT_WIDTH  valid units in out eof word
//  out_vld        out  1          output valid (registered)
//  out_rdy        in   1          downstream ready
//  proto_err      out  1          1-cycle pulse: sof accepted while a frame was open
// BEHAVIOUR
//  - Reset: out_vld=0, out_eof=0, out_eof_units=0, out_data=0, proto_err=0, state=IDLE,
//    residue and latched offset cleared. Reset mid-frame discards the partial frame.
//  - Transfer on vld&rdy. out_* held stable while out_vld & !out_rdy.
//  - in_rdy = (state!=FLUSH) & (!out_vld | out_rdy).
//  - Define rot(x) = x rotated left by off units; hi_mask = first NUM_UNITS-off units.
//  - States:
//    IDLE: non-sof word accepted -> dropped silently. sof word accepted -> off<=in_offset,
//      res<=rot(in), no output. If also eof: e=in_eof_units; if e>off -> FLUSH with
//      cnt=e-off; else frame empty, stay IDLE. Otherwise -> MID.
//    MID: word accepted -> out_data=(res&hi_mask)|(rot(in)&~hi_mask); res<=rot(in).
//      Non-eof: out_eof=0, stay MID. eof, e<=off: out_eof=1, out_eof_units=NUM_UNITS-off+e
//      -> IDLE. eof, e>off: out_eof=0 -> FLUSH with cnt=e-off.
//      sof in MID: proto_err pulse, residue discarded, handle as sof from IDLE.
//    FLUSH: when output reg free, emit out_data=res&hi_mask (unused units 0), out_eof=1,
//      out_eof_units=cnt -> IDLE.
//  - Latency: first output 1 cycle after second input word accepted (off=0 included:
//    uniform one-word delay). Throughput 1 word/cycle except one bubble per FLUSH.
//  - Unit counts never 0; arithmetic in CNT_WIDTH bits, no wrap possible
//    (off<=NUM_UNITS-1, e<=NUM_UNITS).
//  - Data units beyond out_eof_units in an eof word are don't-care-free: driven 0.
// STRUCTURE
//  - Shared include: log2 function macro, CNT_WIDTH/OFF_WIDTH derivation.
//  - Sub-module: instance of the existing rotate utility (SHIFT_LEFT=1, UNIT_SIZE,
//    NUM_UNITS) for rot(in); residue stored already rotated, so a single instance.
//    hi_mask from a small function of off.
//  - Local: 2-bit state (IDLE/MID/FLUSH), res, off, cnt, output register.
// TESTING (UNIT_SIZE=8, NUM_UNITS=8; words as byte lists)
//  1 off=3, 3 words 00..17, eof_units=8 -> out 03..0A, 0B..12, then FLUSH 13..17,
//    eof_units=5, rest 0.
//  2 off=0, 2 words, eof_units=4 -> out word1 unchanged (eof=0), word2 eof_units=4.
//  3 single word sof&eof, off=5, e=5 -> no output; e=7 -> one word 05,06, eof_units=2.
//  4 off=6, 2 words, e=2 -> one output 06,07,08,09, eof=1, eof_units=4, no FLUSH.
//  5 out_rdy low 5 cycles mid-frame -> out_* stable, in_rdy=0, no loss/duplication.
//  6 sof while MID -> proto_err 1 cycle, new frame correct; reset during FLUSH ->
//    out_vld=0 immediately, next frame clean.

Source files
------------

// File: rtl/unit_realigner_pkg.sv
// Shared types and helpers for the unit realigner.
// State encoding, log2 helper and default geometry.
package unit_realigner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MID   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_UNIT_SIZE = 8;
  localparam int DEF_NUM_UNITS = 8;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/unit_realigner_rotate.sv
// Unit-granular word rotator; unit 0 sits at bit 0.
// Ports: data (word), amt (units), rot (rotated word).
module unit_realigner_rotate
  import unit_realigner_pkg::*;
#(
  parameter int SHIFT_LEFT = 1,
  parameter int UNIT_SIZE  = DEF_UNIT_SIZE,
  parameter int NUM_UNITS  = DEF_NUM_UNITS,
  localparam int DW = UNIT_SIZE * NUM_UNITS,
  localparam int AW = log2(NUM_UNITS)
) (
  input  logic [0:DW-1] data,
  input  logic [AW-1:0] amt,
  output logic [0:DW-1] rot
);

  logic [AW-1:0] src;

  // Left: out unit i takes in unit (i+amt) mod N.
  always_comb begin
    rot = '0;
    src = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (SHIFT_LEFT != 0) src = AW'(i) + amt;
      else                 src = AW'(i) - amt;
      rot[i*UNIT_SIZE +: UNIT_SIZE] =
        data[int'(src)*UNIT_SIZE +: UNIT_SIZE];
    end
  end

endmodule

// File: rtl/unit_realigner.sv
// Streaming realigner: drops OFFSET leading units per frame
// and repacks the rest into word-aligned output words.
// Ports: clk/reset, in_* stream (vld/rdy), out_* stream
// (registered vld/rdy), proto_err pulse on sof mid-frame.
module unit_realigner
  import unit_realigner_pkg::*;
#(
  parameter int UNIT_SIZE = DEF_UNIT_SIZE,
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  localparam int DATA_WIDTH = UNIT_SIZE * NUM_UNITS,
  localparam int OFF_WIDTH  = log2(NUM_UNITS),
  localparam int CNT_WIDTH  = OFF_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:DATA_WIDTH-1] in_data,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic [CNT_WIDTH-1:0]  in_eof_units,
  input  logic [OFF_WIDTH-1:0]  in_offset,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [0:DATA_WIDTH-1] out_data,
  output logic                  out_eof,
  output logic [CNT_WIDTH-1:0]  out_eof_units,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  proto_err
);

  localparam logic [CNT_WIDTH-1:0] N_C = CNT_WIDTH'(NUM_UNITS);

  // Mask covering the first n units of a word.
  function automatic logic [0:DATA_WIDTH-1] units_mask(
    input logic [CNT_WIDTH-1:0] n
  );
    logic [0:DATA_WIDTH-1] m;
    m = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      m[i*UNIT_SIZE +: UNIT_SIZE] = {UNIT_SIZE{CNT_WIDTH'(i) < n}};
    return m;
  endfunction

  state_t                state;
  logic [OFF_WIDTH-1:0]  off;
  logic [OFF_WIDTH-1:0]  rot_amt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  off_c;
  logic [CNT_WIDTH-1:0]  in_off_c;
  logic [CNT_WIDTH-1:0]  tail_units;
  logic [0:DATA_WIDTH-1] res;
  logic [0:DATA_WIDTH-1] rot_in;
  logic [0:DATA_WIDTH-1] hi_mask;
  logic [0:DATA_WIDTH-1] tail_mask;
  logic [0:DATA_WIDTH-1] merged;
  logic                  out_free;
  logic                  accept;
  logic                  short_eof;

  assign out_free = !out_vld || out_rdy;
  assign in_rdy   = (state != FLUSH) && out_free;
  assign accept   = in_vld && in_rdy;

  // A sof word is rotated by its own offset, not the latched one.
  assign rot_amt  = in_sof ? in_offset : off;

  unit_realigner_rotate #(
    .SHIFT_LEFT (1),
    .UNIT_SIZE  (UNIT_SIZE),
    .NUM_UNITS  (NUM_UNITS)
  ) u_rot (
    .data (in_data),
    .amt  (rot_amt),
    .rot  (rot_in)
  );

  assign off_c      = {1'b0, off};
  assign in_off_c   = {1'b0, in_offset};
  assign hi_mask    = units_mask(N_C - off_c);
  assign tail_units = N_C - off_c + in_eof_units;
  assign short_eof  = in_eof && (in_eof_units <= off_c);
  assign tail_mask  = short_eof ? units_mask(tail_units) : '1;
  assign merged     = (res & hi_mask) | (rot_in & ~hi_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      off           <= '0;
      cnt           <= '0;
      res           <= '0;
      out_data      <= '0;
      out_eof       <= 1'b0;
      out_eof_units <= '0;
      out_vld       <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      if (out_vld && out_rdy) out_vld <= 1'b0;
      if (state == FLUSH) begin
        if (out_free) begin
          out_data      <= res & units_mask(cnt);
          out_eof       <= 1'b1;
          out_eof_units <= cnt;
          out_vld       <= 1'b1;
          state         <= IDLE;
        end
      end else if (accept) begin
        if (in_sof) begin
          // Restart: any open frame's residue is abandoned.
          proto_err <= (state == MID);
          off       <= in_offset;
          res       <= rot_in;
          if (!in_eof) begin
            state <= MID;
          end else if (in_eof_units > in_off_c) begin
            state <= FLUSH;
            cnt   <= in_eof_units - in_off_c;
          end else begin
            state <= IDLE;
          end
        end else if (state == MID) begin
          out_data <= merged & tail_mask;
          out_vld  <= 1'b1;
          res      <= rot_in;
          if (!in_eof) begin
            out_eof       <= 1'b0;
            out_eof_units <= '0;
          end else if (short_eof) begin
            out_eof       <= 1'b1;
            out_eof_units <= tail_units;
            state         <= IDLE;
          end else begin
            out_eof       <= 1'b0;
            out_eof_units <= '0;
            state         <= FLUSH;
            cnt           <= in_eof_units - off_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_unit_realigner.sv
// Directed bench for unit_realigner (8 units x 8 bits).
// Hand-computed expected words, one check task.
module tb_unit_realigner;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:63] in_data;
  logic        in_sof;
  logic        in_eof;
  logic [3:0]  in_eof_units;
  logic [2:0]  in_offset;
  logic        in_vld;
  logic        in_rdy;
  logic [0:63] out_data;
  logic        out_eof;
  logic [3:0]  out_eof_units;
  logic        out_vld;
  logic        out_rdy;
  logic        proto_err;

  typedef struct {
    logic [0:63] d;
    logic        e;
    logic [3:0]  u;
  } beat_t;

  beat_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int pe_cnt = 0;

  unit_realigner dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_sof        (in_sof),
    .in_eof        (in_eof),
    .in_eof_units  (in_eof_units),
    .in_offset     (in_offset),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .out_data      (out_data),
    .out_eof       (out_eof),
    .out_eof_units (out_eof_units),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_vld && out_rdy)
      q.push_back('{out_data, out_eof, out_eof_units});
    if (proto_err) pe_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [0:63] seqw(input logic [7:0] b);
    logic [0:63] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b + 8'(i);
    return r;
  endfunction

  task automatic send(input logic [0:63] d,
                      input logic s,
                      input logic e,
                      input logic [3:0] eu,
                      input logic [2:0] o);
    int n;
    in_data = d;
    in_sof = s;
    in_eof = e;
    in_eof_units = eu;
    in_offset = o;
    in_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_acc", 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_sof = 1'b0;
    in_eof = 1'b0;
  endtask

  task automatic expect_out(input string tag,
                            input logic [0:63] d,
                            input logic e,
                            input logic [3:0] u);
    int n;
    beat_t b;
    n = 0;
    while (q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_avail"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      b = q.pop_front();
      chk({tag, "_data"}, b.d, d);
      chk({tag, "_eof"}, 64'(b.e), 64'(e));
      if (e) chk({tag, "_units"}, 64'(b.u), 64'(u));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_data = '0;
    in_sof = 1'b0;
    in_eof = 1'b0;
    in_eof_units = '0;
    in_offset = '0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_eof", 64'(out_eof), 64'd0);
    chk("rst_units", 64'(out_eof_units), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_irdy", 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // off=3, three full words
    send(seqw(8'h00), 1'b1, 1'b0, 4'd0, 3'd3);
    send(seqw(8'h08), 1'b0, 1'b0, 4'd0, 3'd0);
    send(seqw(8'h10), 1'b0, 1'b1, 4'd8, 3'd0);
    expect_out("t1a", 64'h03040506_0708090A, 1'b0, 4'd0);
    expect_out("t1b", 64'h0B0C0D0E_0F101112, 1'b0, 4'd0);
    expect_out("t1c", 64'h13141516_17000000, 1'b1, 4'd5);

    // off=0, second word partial
    send(seqw(8'h20), 1'b1, 1'b0, 4'd0, 3'd0);
    send(seqw(8'h28), 1'b0, 1'b1, 4'd4, 3'd0);
    expect_out("t2a", 64'h20212223_24252627, 1'b0, 4'd0);
    expect_out("t2b", 64'h28292A2B_00000000, 1'b1, 4'd4);

    // single word frames
    send(seqw(8'h40), 1'b1, 1'b1, 4'd5, 3'd5);
    idle(5);
    chk("t3_empty", 64'(q.size()), 64'd0);
    send(seqw(8'h00), 1'b1, 1'b1, 4'd7, 3'd5);
    expect_out("t3", 64'h05060000_00000000, 1'b1, 4'd2);

    // short eof absorbed into last merged word
    send(seqw(8'h00), 1'b1, 1'b0, 4'd0, 3'd6);
    send(seqw(8'h08), 1'b0, 1'b1, 4'd2, 3'd0);
    expect_out("t4", 64'h06070809_00000000, 1'b1, 4'd4);
    idle(5);
    chk("t4_noflush", 64'(q.size()), 64'd0);

    // downstream stall mid-frame
    send(seqw(8'h50), 1'b1, 1'b0, 4'd0, 3'd1);
    send(seqw(8'h58), 1'b0, 1'b0, 4'd0, 3'd0);
    out_rdy = 1'b0;
    fork
      send(seqw(8'h60), 1'b0, 1'b1, 4'd8, 3'd0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t5_vld", 64'(out_vld), 64'd1);
          chk("t5_data", out_data, 64'h51525354_55565758);
          chk("t5_irdy", 64'(in_rdy), 64'd0);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join
    expect_out("t5a", 64'h51525354_55565758, 1'b0, 4'd0);
    expect_out("t5b", 64'h595A5B5C_5D5E5F60, 1'b0, 4'd0);
    expect_out("t5c", 64'h61626364_65666700, 1'b1, 4'd7);
    idle(3);
    chk("t5_extra", 64'(q.size()), 64'd0);

    // sof while a frame is open
    pe_cnt = 0;
    send(seqw(8'h70), 1'b1, 1'b0, 4'd0, 3'd2);
    send(seqw(8'h80), 1'b1, 1'b0, 4'd0, 3'd0);
    send(seqw(8'h88), 1'b0, 1'b1, 4'd8, 3'd0);
    expect_out("t6a", 64'h80818283_84858687, 1'b0, 4'd0);
    expect_out("t6b", 64'h88898A8B_8C8D8E8F, 1'b1, 4'd8);
    chk("t6_perr", 64'(pe_cnt), 64'd1);

    // reset while FLUSH is pending
    out_rdy = 1'b0;
    send(seqw(8'h90), 1'b1, 1'b0, 4'd0, 3'd0);
    send(seqw(8'h98), 1'b0, 1'b1, 4'd8, 3'd0);
    @(negedge clk);
    chk("t6_fl_vld", 64'(out_vld), 64'd1);
    chk("t6_fl_irdy", 64'(in_rdy), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_vld", 64'(out_vld), 64'd0);
    chk("t6_rst_eof", 64'(out_eof), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_rdy = 1'b1;
    send(seqw(8'hA0), 1'b1, 1'b1, 4'd8, 3'd3);
    expect_out("t6c", 64'hA3A4A5A6_A7000000, 1'b1, 4'd5);
    idle(5);
    chk("t6_extra", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
